// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu: single-outstanding load/store initiator between EXU, data memory and WBU.
// Optional misalignment trap enabled by defining YSYX_23060332_LSU_MISALIGN_CHECK_EN.
module ysyx_23060332_lsu #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [3:0] LAT = 4'(RD_LATENCY);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_waddr_q, mem_waddr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_wmask_q, mem_wmask_d;
    logic        mem_ren_q, mem_ren_d;
    logic [31:0] mem_raddr_q, mem_raddr_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    // Lanes that fall past byte 3 are dropped by the 4-bit result.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] base;
        case (size)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    return {{24{~uns & sh[7]}}, sh[7:0]};
            2'd1:    return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            default: return (off != 2'd0);
        endcase
    endfunction
`endif

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        mem_wen_d    = mem_wen_q;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        mem_ren_d    = mem_ren_q;
        mem_raddr_d  = mem_raddr_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d  = req_addr[1:0];
                    size_d = req_size;
                    uns_d  = req_unsigned;
`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (req_wen) begin
`else
                    if (req_wen) begin
`endif
                        state_d     = STORE;
                        mem_wen_d   = 1'b1;
                        mem_waddr_d = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                        mem_wmask_d = {4'b0000, lane_mask(req_size, req_addr[1:0])};
                    end else begin
                        state_d     = LOAD;
                        cnt_d       = 4'd0;
                        mem_ren_d   = 1'b1;
                        mem_raddr_d = {req_addr[31:2], 2'b00};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STORE: begin
                state_d      = RESP;
                mem_wen_d    = 1'b0;
                mem_waddr_d  = 32'd0;
                mem_wdata_d  = 32'd0;
                mem_wmask_d  = 8'd0;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'd0;
                resp_err_d   = 1'b0;
            end
            LOAD: begin
                if (cnt_q == LAT) begin
                    state_d      = RESP;
                    cnt_d        = 4'd0;
                    mem_ren_d    = 1'b0;
                    mem_raddr_d  = 32'd0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extend(mem_rdata, off_q, size_q, uns_q);
                    resp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = 4'd0;
                mem_wen_d    = 1'b0;
                mem_ren_d    = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_waddr_q  <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wmask_q  <= 8'd0;
            mem_ren_q    <= 1'b0;
            mem_raddr_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            mem_wen_q    <= mem_wen_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_ren_q    <= mem_ren_d;
            mem_raddr_q  <= mem_raddr_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = rst_n & (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_wen    = mem_wen_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign mem_ren    = mem_ren_q;
    assign mem_raddr  = mem_raddr_q;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Self-checking bench for ysyx_23060332_lsu: one instance with RD_LATENCY=1, one with RD_LATENCY=0.
module tb_ysyx_23060332_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] mem_rdata = 32'd0, mem_word = 32'd0;
    logic        req_ready, resp_valid, resp_err, mem_wen, mem_ren;
    logic [31:0] resp_rdata, mem_waddr, mem_wdata, mem_raddr;
    logic [7:0]  mem_wmask;

    logic        req_valid0 = 1'b0, resp_ready0 = 1'b0;
    logic        req_ready0, resp_valid0, resp_err0, mem_wen0, mem_ren0;
    logic [31:0] resp_rdata0, mem_waddr0, mem_wdata0, mem_raddr0, mem_rdata0;
    logic [7:0]  mem_wmask0;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];
    logic [32:0] exp_r;

    always #5 clk = ~clk;

    ysyx_23060332_lsu #(.RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata));

    ysyx_23060332_lsu #(.RD_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .mem_wen(mem_wen0), .mem_waddr(mem_waddr0), .mem_wdata(mem_wdata0), .mem_wmask(mem_wmask0),
        .mem_ren(mem_ren0), .mem_raddr(mem_raddr0), .mem_rdata(mem_rdata0));

    // One-cycle memory: data only valid when the read was enabled the cycle before.
    always @(posedge clk) mem_rdata <= mem_ren ? mem_word : 32'hDEADBEEF;

    // Combinational memory whose contents are a function of the word address.
    always_comb mem_rdata0 = mem_ren0 ? {mem_raddr0[15:0], ~mem_raddr0[15:0]} : 32'hDEADBEEF;

    logic [31:0] st_addr [4] = '{32'h80000003, 32'h80000002, 32'h80000010, 32'h80000001};
    logic [1:0]  st_size [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] st_data [4] = '{32'h000000AB, 32'h00001234, 32'hDEADBEEF, 32'h0000005A};
    logic [31:0] st_edata[4] = '{32'hAB000000, 32'h12340000, 32'hDEADBEEF, 32'h00005A00};
    logic [7:0]  st_emask[4] = '{8'h08, 8'h0C, 8'h0F, 8'h02};

    logic [31:0] ld_addr [6] = '{32'h80000002, 32'h80000002, 32'h80000001, 32'h80000004, 32'h80000000, 32'h80000003};
    logic [1:0]  ld_size [6] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
    logic        ld_uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ld_word [6] = '{32'h80011234, 32'h80011234, 32'h000080FF, 32'hCAFEBABE, 32'h123456F0, 32'h7F000000};
    logic [31:0] ld_exp  [6] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFF80, 32'hCAFEBABE, 32'h000000F0, 32'h0000007F};

    // Drives one request for a cycle from a negedge; returns at the negedge after the handshake edge.
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        checks++; if ({mem_wen, mem_ren, mem_wmask} !== 10'd0) begin errors++; $display("FAIL rst_mem got %b exp 0", {mem_wen, mem_ren, mem_wmask}); end
        checks++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp got %h/%b exp 0/0", resp_rdata, resp_err); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b%b exp 11", req_ready, req_ready0); end
    endtask

    task automatic test_store();
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b0, 32'd0});
            issue(1'b1, st_addr[i], st_data[i], st_size[i], 1'b0);
            checks++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0) begin errors++; $display("FAIL st%0d_strobes got wen %b ren %b exp 1 0", i, mem_wen, mem_ren); end
            checks++; if (mem_waddr !== {st_addr[i][31:2], 2'b00}) begin errors++; $display("FAIL st%0d_waddr got %h exp %h", i, mem_waddr, {st_addr[i][31:2], 2'b00}); end
            checks++; if (mem_wdata !== st_edata[i]) begin errors++; $display("FAIL st%0d_wdata got %h exp %h", i, mem_wdata, st_edata[i]); end
            checks++; if (mem_wmask !== st_emask[i]) begin errors++; $display("FAIL st%0d_wmask got %h exp %h", i, mem_wmask, st_emask[i]); end
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL st%0d_early_resp got %b exp 0", i, resp_valid); end
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1 || mem_wen !== 1'b0) begin errors++; $display("FAIL st%0d_resp_lat got valid %b wen %b exp 1 0", i, resp_valid, mem_wen); end
            exp_r = sb.pop_front();
            checks++; if ({resp_err, resp_rdata} !== exp_r) begin errors++; $display("FAIL st%0d_resp got %h exp %h", i, {resp_err, resp_rdata}, exp_r); end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL st%0d_idle got valid %b ready %b exp 0 1", i, resp_valid, req_ready); end
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 6; i++) begin
            mem_word = ld_word[i];
            sb.push_back({1'b0, ld_exp[i]});
            issue(1'b0, ld_addr[i], 32'hFFFFFFFF, ld_size[i], ld_uns[i]);
            checks++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0) begin errors++; $display("FAIL ld%0d_strobes got ren %b wen %b exp 1 0", i, mem_ren, mem_wen); end
            checks++; if (mem_raddr !== {ld_addr[i][31:2], 2'b00}) begin errors++; $display("FAIL ld%0d_raddr got %h exp %h", i, mem_raddr, {ld_addr[i][31:2], 2'b00}); end
            @(negedge clk);
            checks++; if (mem_ren !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_wait got ren %b valid %b exp 1 0", i, mem_ren, resp_valid); end
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1 || mem_ren !== 1'b0) begin errors++; $display("FAIL ld%0d_resp_lat got valid %b ren %b exp 1 0", i, resp_valid, mem_ren); end
            exp_r = sb.pop_front();
            checks++; if ({resp_err, resp_rdata} !== exp_r) begin errors++; $display("FAIL ld%0d_rdata got %h exp %h", i, {resp_err, resp_rdata}, exp_r); end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ld%0d_idle got valid %b ready %b exp 0 1", i, resp_valid, req_ready); end
        end
    endtask

    task automatic test_misaligned();
`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
        sb.push_back({1'b1, 32'd0});
        issue(1'b1, 32'h80000002, 32'h11223344, 2'd2, 1'b0);
        checks++; if (resp_valid !== 1'b1 || mem_wen !== 1'b0) begin errors++; $display("FAIL mis_resp got valid %b wen %b exp 1 0", resp_valid, mem_wen); end
        exp_r = sb.pop_front();
        checks++; if ({resp_err, resp_rdata} !== exp_r) begin errors++; $display("FAIL mis_err got %h exp %h", {resp_err, resp_rdata}, exp_r); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (mem_wen !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL mis_after got wen %b valid %b exp 0 0", mem_wen, resp_valid); end
`else
        sb.push_back({1'b0, 32'd0});
        issue(1'b1, 32'h80000002, 32'h11223344, 2'd2, 1'b0);
        checks++; if (mem_wen !== 1'b1 || mem_wmask !== 8'h0C) begin errors++; $display("FAIL mis_wmask got wen %b mask %h exp 1 0c", mem_wen, mem_wmask); end
        checks++; if (mem_wdata !== 32'h33440000) begin errors++; $display("FAIL mis_wdata got %h exp 33440000", mem_wdata); end
        @(negedge clk);
        exp_r = sb.pop_front();
        checks++; if (resp_valid !== 1'b1 || {resp_err, resp_rdata} !== exp_r) begin errors++; $display("FAIL mis_resp got %b %h exp 1 %h", resp_valid, {resp_err, resp_rdata}, exp_r); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
`endif
    endtask

    task automatic test_backpressure();
        mem_word = 32'h13572468;
        sb.push_back({1'b0, 32'h13572468});
        issue(1'b0, 32'h80000008, 32'd0, 2'd2, 1'b0);
        for (int i = 0; i < 10 && resp_valid !== 1'b1; i++) @(negedge clk);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b exp 1", resp_valid); end
        exp_r = sb.pop_front();
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2;
        for (int c = 0; c < 5; c++) begin
            checks++; if (resp_valid !== 1'b1 || {resp_err, resp_rdata} !== exp_r) begin errors++; $display("FAIL bp_hold%0d got %b %h exp 1 %h", c, resp_valid, {resp_err, resp_rdata}, exp_r); end
            checks++; if ({req_ready, mem_wen, mem_ren} !== 3'b000) begin errors++; $display("FAIL bp_quiet%0d got %b exp 000", c, {req_ready, mem_wen, mem_ren}); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b0;
        checks++; if ({resp_valid, req_ready, mem_wen} !== 3'b010) begin errors++; $display("FAIL bp_release got %b exp 010", {resp_valid, req_ready, mem_wen}); end
        @(negedge clk);
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL bp_no_accept got %b exp 0", mem_wen); end
    endtask

    task automatic test_reset_mid_load();
        mem_word = 32'h0BADF00D;
        issue(1'b0, 32'h80000020, 32'd0, 2'd2, 1'b0);
        checks++; if (mem_ren !== 1'b1) begin errors++; $display("FAIL rml_ren got %b exp 1", mem_ren); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({mem_ren, mem_wen, req_ready, resp_valid} !== 4'b0000) begin errors++; $display("FAIL rml_abort got %b exp 0000", {mem_ren, mem_wen, req_ready, resp_valid}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rml_after%0d got valid %b ready %b exp 0 1", c, resp_valid, req_ready); end
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back({1'b0, 32'h0100FEFF});
        sb.push_back({1'b0, 32'hFFFFFFFD});
        req_wen = 1'b0; req_addr = 32'h80000100; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid0 = 1'b1;
        @(negedge clk);
        checks++; if (mem_ren0 !== 1'b1 || mem_raddr0 !== 32'h80000100) begin errors++; $display("FAIL b2b_ren_a got %b %h exp 1 80000100", mem_ren0, mem_raddr0); end
        req_addr = 32'h80000205; req_size = 2'd0; resp_ready0 = 1'b1;
        @(negedge clk);
        exp_r = sb.pop_front();
        checks++; if (resp_valid0 !== 1'b1 || {resp_err0, resp_rdata0} !== exp_r) begin errors++; $display("FAIL b2b_resp_a got %b %h exp 1 %h", resp_valid0, {resp_err0, resp_rdata0}, exp_r); end
        @(negedge clk);
        checks++; if ({req_ready0, resp_valid0, mem_ren0} !== 3'b100) begin errors++; $display("FAIL b2b_gap got %b exp 100", {req_ready0, resp_valid0, mem_ren0}); end
        @(negedge clk);
        req_valid0 = 1'b0;
        checks++; if (mem_ren0 !== 1'b1 || mem_raddr0 !== 32'h80000204) begin errors++; $display("FAIL b2b_ren_b got %b %h exp 1 80000204", mem_ren0, mem_raddr0); end
        @(negedge clk);
        exp_r = sb.pop_front();
        checks++; if (resp_valid0 !== 1'b1 || {resp_err0, resp_rdata0} !== exp_r) begin errors++; $display("FAIL b2b_resp_b got %b %h exp 1 %h", resp_valid0, {resp_err0, resp_rdata0}, exp_r); end
        @(negedge clk);
        resp_ready0 = 1'b0;
        checks++; if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_end got %b %b exp 0 1", resp_valid0, req_ready0); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misaligned();
        test_backpressure();
        test_reset_mid_load();
        test_back_to_back();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
